// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and entry type for the write-back queue
package wb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] address;
        logic [DATA_W-1:0]     data;
    } wb_entry;
endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-match search over the pending queue entries
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wb_entry [DEPTH-1:0]    entries,
    input  logic [PTR_W-1:0]       head,
    input  logic [CNT_W-1:0]       count,
    input  logic [REG_ADDR_W-1:0]  addr,
    output logic                   hit,
    output logic [DATA_W-1:0]      data
);
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr != REG_ZERO) &&
                (entries[idx].address == addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - buffered write-back into the register file with read forwarding
module wb_write_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [REG_ADDR_W-1:0] reqAddress,
    input  logic [DATA_W-1:0]     reqData,
    input  logic                  drainHold,
    output logic                  writeEnable,
    output logic [REG_ADDR_W-1:0] writeAddress,
    output logic [DATA_W-1:0]     writeData,
    input  logic [REG_ADDR_W-1:0] getAddress1,
    input  logic [REG_ADDR_W-1:0] getAddress2,
    output logic                  fwdHit1,
    output logic [DATA_W-1:0]     fwdData1,
    output logic                  fwdHit2,
    output logic [DATA_W-1:0]     fwdData2,
    output logic [CNT_W-1:0]      pendingCount
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry [DEPTH-1:0] entries;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic                push;
    logic                pop;
    logic                not_empty;

    assign not_empty    = (count != '0);
    assign reqReady     = (count != CNT_W'(DEPTH));
    // Writes to r0 complete the handshake but are never stored.
    assign push         = reqValid && reqReady && (reqAddress != REG_ZERO);
    assign writeEnable  = not_empty && !drainHold;
    assign pop          = writeEnable;
    assign writeAddress = not_empty ? entries[head].address : REG_ZERO;
    assign writeData    = not_empty ? entries[head].data    : '0;
    assign pendingCount = count;

    always_ff @(posedge CLK) begin
        if (push) begin
            entries[tail] <= '{address: reqAddress, data: reqData};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_fwd1 (
        .entries (entries),
        .head    (head),
        .count   (count),
        .addr    (getAddress1),
        .hit     (fwdHit1),
        .data    (fwdData1)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_fwd2 (
        .entries (entries),
        .head    (head),
        .count   (count),
        .addr    (getAddress2),
        .hit     (fwdHit2),
        .data    (fwdData2)
    );
endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - randomized self-checking bench for wb_write_queue
module tb_wb_write_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             CLK;
    logic             RST;
    logic             reqValid;
    logic             reqReady;
    logic [4:0]       reqAddress;
    logic [31:0]      reqData;
    logic             drainHold;
    logic             writeEnable;
    logic [4:0]       writeAddress;
    logic [31:0]      writeData;
    logic [4:0]       getAddress1;
    logic [4:0]       getAddress2;
    logic             fwdHit1;
    logic [31:0]      fwdData1;
    logic             fwdHit2;
    logic [31:0]      fwdData2;
    logic [CNT_W-1:0] pendingCount;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqAddress   (reqAddress),
        .reqData      (reqData),
        .drainHold    (drainHold),
        .writeEnable  (writeEnable),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .getAddress1  (getAddress1),
        .getAddress2  (getAddress2),
        .fwdHit1      (fwdHit1),
        .fwdData1     (fwdData1),
        .fwdHit2      (fwdHit2),
        .fwdData2     (fwdData2),
        .pendingCount (pendingCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    ent_t exp_commits[$];
    ent_t got_commits[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void model_fwd(input logic [4:0] addr, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        if (addr != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a == addr) begin
                    hit  = 1'b1;
                    data = mq[i].d;
                    break;
                end
            end
        end
    endfunction

    task automatic tick();
        bit   acc;
        bit   drn;
        ent_t e;
        #1;
        if (writeEnable === 1'b1 && !RST) begin
            e.a = writeAddress;
            e.d = writeData;
            got_commits.push_back(e);
        end
        acc = reqValid && (mq.size() != DEPTH);
        drn = (mq.size() != 0) && !drainHold;
        @(posedge CLK);
        if (RST) begin
            mq.delete();
        end else begin
            if (drn) exp_commits.push_back(mq.pop_front());
            if (acc && reqAddress != 5'd0) begin
                e.a = reqAddress;
                e.d = reqData;
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; reqValid = 1'b0; reqAddress = '0; reqData = '0;
        drainHold = 1'b0; getAddress1 = 5'd5; getAddress2 = 5'd0;
        tick(); tick();
        RST = 1'b0;
        #1;
        checks++; if (writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %0b expected 0", writeEnable); end
        checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b expected 1", reqReady); end
        checks++; if (pendingCount !== 3'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", pendingCount); end
        checks++; if (fwdHit1 !== 1'b0 || fwdData1 !== 32'd0) begin errors++; $display("FAIL reset_fwd got %0b/%0h expected 0/0", fwdHit1, fwdData1); end
        tick();
    endtask

    task automatic test_single();
        reqValid = 1'b1; reqAddress = 5'd5; reqData = 32'hDEADBEEF;
        tick();
        reqValid = 1'b0;
        #1;
        checks++;
        if (writeEnable !== 1'b1 || writeAddress !== 5'd5 || writeData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_port got we=%0b a=%0d d=%0h expected we=1 a=5 d=deadbeef", writeEnable, writeAddress, writeData);
        end
        checks++; if (pendingCount !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d expected 1", pendingCount); end
        tick();
        checks++; if (pendingCount !== 3'd0 || writeEnable !== 1'b0) begin errors++; $display("FAIL single_drained got cnt=%0d we=%0b expected 0/0", pendingCount, writeEnable); end
    endtask

    task automatic test_hold_order();
        logic [4:0]  addrs[4];
        logic [31:0] datas[4];
        addrs = '{5'd1, 5'd2, 5'd3, 5'd1};
        datas = '{32'd1, 32'd2, 32'd3, 32'd4};
        drainHold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            reqValid = 1'b1; reqAddress = addrs[i]; reqData = datas[i];
            tick();
        end
        reqAddress = 5'd7; reqData = 32'h77;
        getAddress1 = 5'd1; getAddress2 = 5'd2;
        #1;
        checks++; if (pendingCount !== 3'd4) begin errors++; $display("FAIL hold_count got %0d expected 4", pendingCount); end
        checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL hold_full_ready got %0b expected 0", reqReady); end
        checks++; if (fwdHit1 !== 1'b1 || fwdData1 !== 32'd4) begin errors++; $display("FAIL hold_fwd1 got %0b/%0h expected 1/4", fwdHit1, fwdData1); end
        checks++; if (fwdHit2 !== 1'b1 || fwdData2 !== 32'd2) begin errors++; $display("FAIL hold_fwd2 got %0b/%0h expected 1/2", fwdHit2, fwdData2); end
        tick();
        reqValid = 1'b0; drainHold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (writeEnable !== 1'b1 || writeAddress !== addrs[i] || writeData !== datas[i]) begin
                errors++;
                $display("FAIL hold_drain%0d got we=%0b a=%0d d=%0h expected 1/%0d/%0h", i, writeEnable, writeAddress, writeData, addrs[i], datas[i]);
            end
            tick();
            if (i == 0) begin
                checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL hold_ready_after got %0b expected 1", reqReady); end
            end
        end
        checks++; if (pendingCount !== 3'd0) begin errors++; $display("FAIL hold_empty got %0d expected 0", pendingCount); end
    endtask

    task automatic test_r0();
        reqValid = 1'b1; reqAddress = 5'd0; reqData = 32'h1234; getAddress2 = 5'd0;
        #1;
        checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b expected 1", reqReady); end
        tick();
        reqValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (writeEnable !== 1'b0 || pendingCount !== 3'd0) begin errors++; $display("FAIL r0_dropped got we=%0b cnt=%0d expected 0/0", writeEnable, pendingCount); end
            checks++; if (fwdHit2 !== 1'b0) begin errors++; $display("FAIL r0_fwd got %0b expected 0", fwdHit2); end
            tick();
        end
    endtask

    task automatic test_stream();
        drainHold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            reqValid = 1'b1; reqAddress = 5'($urandom_range(1, 31)); reqData = $urandom;
            tick();
        end
        drainHold = 1'b0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            reqAddress = 5'($urandom_range(1, 31)); reqData = $urandom;
            #1;
            checks++;
            if (pendingCount !== 3'd2 || reqReady !== 1'b1 || writeEnable !== 1'b1 ||
                writeAddress !== mq[0].a || writeData !== mq[0].d) begin
                errors++;
                $display("FAIL stream%0d got cnt=%0d rdy=%0b we=%0b a=%0d d=%0h expected 2/1/1/%0d/%0h",
                         i, pendingCount, reqReady, writeEnable, writeAddress, writeData, mq[0].a, mq[0].d);
            end
            tick();
        end
        reqValid = 1'b0;
        tick(); tick();
        checks++; if (pendingCount !== 3'd0) begin errors++; $display("FAIL stream_empty got %0d expected 0", pendingCount); end
    endtask

    task automatic test_random();
        logic        eh1, eh2;
        logic [31:0] ed1, ed2;
        logic [4:0]  ea;
        logic [31:0] ed;
        for (int i = 0; i < 200; i++) begin
            reqValid    = 1'($urandom_range(0, 1));
            reqAddress  = 5'($urandom_range(0, 7));
            reqData     = $urandom;
            drainHold   = ($urandom_range(0, 3) == 0);
            getAddress1 = 5'($urandom_range(0, 7));
            getAddress2 = 5'($urandom_range(0, 7));
            #1;
            model_fwd(getAddress1, eh1, ed1);
            model_fwd(getAddress2, eh2, ed2);
            ea = (mq.size() != 0) ? mq[0].a : 5'd0;
            ed = (mq.size() != 0) ? mq[0].d : 32'd0;
            checks++;
            if (reqReady !== (mq.size() != DEPTH) || pendingCount !== CNT_W'(mq.size()) ||
                writeEnable !== ((mq.size() != 0) && !drainHold) || writeAddress !== ea || writeData !== ed) begin
                errors++;
                $display("FAIL rand_port%0d got rdy=%0b cnt=%0d we=%0b a=%0d d=%0h expected cnt=%0d a=%0d d=%0h",
                         i, reqReady, pendingCount, writeEnable, writeAddress, writeData, mq.size(), ea, ed);
            end
            checks++;
            if (fwdHit1 !== eh1 || fwdData1 !== ed1 || fwdHit2 !== eh2 || fwdData2 !== ed2) begin
                errors++;
                $display("FAIL rand_fwd%0d got %0b/%0h %0b/%0h expected %0b/%0h %0b/%0h",
                         i, fwdHit1, fwdData1, fwdHit2, fwdData2, eh1, ed1, eh2, ed2);
            end
            tick();
        end
        reqValid = 1'b0; drainHold = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) tick();
    endtask

    task automatic test_reset_mid();
        drainHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reqValid = 1'b1; reqAddress = 5'(10 + i); reqData = 32'hBAD0 + i;
            tick();
        end
        reqValid = 1'b0;
        #1;
        checks++; if (pendingCount !== 3'd3) begin errors++; $display("FAIL rstmid_count3 got %0d expected 3", pendingCount); end
        RST = 1'b1;
        tick();
        RST = 1'b0; drainHold = 1'b0;
        #1;
        checks++; if (pendingCount !== 3'd0 || writeEnable !== 1'b0) begin errors++; $display("FAIL rstmid_cleared got cnt=%0d we=%0b expected 0/0", pendingCount, writeEnable); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_commit_order();
        checks++;
        if (got_commits.size() != exp_commits.size()) begin
            errors++;
            $display("FAIL commit_total got %0d expected %0d", got_commits.size(), exp_commits.size());
        end else begin
            for (int i = 0; i < exp_commits.size(); i++) begin
                checks++;
                if (got_commits[i].a !== exp_commits[i].a || got_commits[i].d !== exp_commits[i].d) begin
                    errors++;
                    $display("FAIL commit%0d got %0d/%0h expected %0d/%0h", i, got_commits[i].a, got_commits[i].d, exp_commits[i].a, exp_commits[i].d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold_order();
        test_r0();
        test_stream();
        test_random();
        test_reset_mid();
        test_commit_order();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
